imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Receives a framed byte stream (for example from a UART receiver) and writes
// the payload into an instruction BRAM. The CPU core is held in reset until a
// complete image has been written.
//
// Frame: SYNC_BYTE, LEN_LO, LEN_HI, then LEN 32-bit words, each sent as four
// bytes least-significant first. LEN is a 16-bit word count.
//
// Byte handshake: a byte transfers on a rising edge where in_valid and
// in_ready are both 1. in_ready is not a function of in_valid. It is high in
// every state except DONE, including the cycle in which a BRAM write is issued.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-low reset
//   in_data      received byte
//   in_valid     in_data is valid
//   in_ready     loader can accept a byte
//   reload       single-cycle request to start a new load (sampled in DONE)
//   mem_en       BRAM port enable (pulses together with mem_we)
//   mem_we       BRAM write strobe, one cycle per word
//   mem_addr     BRAM word address
//   mem_wdata    BRAM write data
//   cpu_rst      active-high hold-in-reset for the core
//   load_done    image written and core released
//   load_err     sticky error (bad length or inter-byte timeout)
//   o_dbg_state  current FSM state, for debug and checkers
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int         ADDR_WIDTH = 10,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         TIMEOUT    = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  reload,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_rst,
    output logic                  load_done,
    output logic                  load_err,
    output logic [2:0]            o_dbg_state
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [15:0]           r_len;
    logic [1:0]            r_byte_idx;
    logic [23:0]           r_asm;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [TW-1:0]         r_idle_cnt;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_wdata;
    logic                  r_load_err;

    logic                  w_accept;
    logic                  w_in_frame;
    logic                  w_timeout;
    logic [15:0]           w_len;
    logic                  w_len_bad;
    logic                  w_word_done;
    logic                  w_last_word;

    assign w_accept   = in_valid && in_ready;
    assign w_in_frame = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) || (r_state == S_DATA);
    // Fires on the TIMEOUT-th consecutive clock without an accepted byte.
    assign w_timeout  = w_in_frame && !w_accept && (r_idle_cnt == TW'(TIMEOUT - 1));
    assign w_len      = {in_data, r_len[7:0]};
    // LEN == 2**ADDR_WIDTH still fits exactly; anything larger would wrap.
    assign w_len_bad  = ({16'd0, w_len} > (32'd1 << ADDR_WIDTH));
    assign w_word_done = (r_state == S_DATA) && w_accept && (r_byte_idx == 2'd3);
    assign w_last_word = (({{(32-ADDR_WIDTH){1'b0}}, r_addr} + 32'd1) == {16'd0, r_len});

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (in_data == SYNC_BYTE)) w_state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_timeout)     w_state_nxt = S_IDLE;
                else if (w_accept) w_state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end else if (w_accept) begin
                    if (w_len == 16'd0)  w_state_nxt = S_DONE;
                    else if (w_len_bad)  w_state_nxt = S_IDLE;
                    else                 w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_timeout)                       w_state_nxt = S_IDLE;
                else if (w_word_done && w_last_word) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (reload) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: length capture, word assembly, BRAM write, timeout, error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len       <= '0;
            r_byte_idx  <= '0;
            r_asm       <= '0;
            r_addr      <= '0;
            r_idle_cnt  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_load_err  <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;

            if (!w_in_frame || w_accept || w_timeout) r_idle_cnt <= '0;
            else                                      r_idle_cnt <= r_idle_cnt + TW'(1);

            if (w_timeout) begin
                // Partial word is discarded, nothing is written.
                r_byte_idx <= '0;
                r_asm      <= '0;
                r_load_err <= 1'b1;
            end else if (w_accept) begin
                case (r_state)
                    S_IDLE: begin
                        if (in_data == SYNC_BYTE) r_load_err <= 1'b0;
                    end
                    S_LEN_LO: begin
                        r_len[7:0] <= in_data;
                    end
                    S_LEN_HI: begin
                        r_len      <= w_len;
                        r_addr     <= '0;
                        r_byte_idx <= '0;
                        r_asm      <= '0;
                        if ((w_len != 16'd0) && w_len_bad) r_load_err <= 1'b1;
                    end
                    S_DATA: begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_addr;
                            r_mem_wdata <= {in_data, r_asm};
                            r_addr      <= r_addr + 1'b1;
                            r_asm       <= '0;
                        end else begin
                            // Shift in from the top: after three bytes r_asm holds {b2, b1, b0}.
                            r_asm <= {in_data, r_asm[23:8]};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready    = (r_state != S_DONE);
    assign cpu_rst     = (r_state != S_DONE);
    assign load_done   = (r_state == S_DONE);
    assign load_err    = r_load_err;
    assign mem_en      = r_mem_we;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign o_dbg_state = r_state;

endmodule
